// File: rtl/univ_shift_register.sv
// Universal shift register: hold / shift up / shift down / parallel load,
// serial in and out at both ends, plus a counted burst-shift engine.
// A burst loads pdata, then shifts it nbits places (clamped to WIDTH) on its
// own, with busy high while shifting and a one-cycle done pulse at the end.
// Optional macro USR_ROTATE_EN: burst shifts rotate instead of taking
// sin_lo/sin_hi. Manual modes behave the same either way.

// Per-bit next-state select: hold, take the up-neighbour, the down-neighbour,
// or the load bit.
module usr_bit_cell (
  input  logic [1:0] i_op,
  input  logic       i_q,
  input  logic       i_up,
  input  logic       i_dn,
  input  logic       i_ld,
  output logic       o_d
);
  // 4:1 mux on the operation code
  always_comb begin
    o_d = i_q;
    case (i_op)
      2'b01:   o_d = i_up;
      2'b10:   o_d = i_dn;
      2'b11:   o_d = i_ld;
      default: o_d = i_q;
    endcase
  end
endmodule

module univ_shift_register #(
  parameter int WIDTH = 4,
  parameter int NB_W  = $clog2(WIDTH+1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [1:0]       mode,
  input  logic             sin_lo,
  input  logic             sin_hi,
  input  logic [WIDTH-1:0] pdata,
  input  logic             start,
  input  logic             dir,
  input  logic [NB_W-1:0]  nbits,
  output logic [WIDTH-1:0] q,
  output logic             sout_hi,
  output logic             sout_lo,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_UP   = 2'b01;
  localparam logic [1:0] OP_DN   = 2'b10;
  localparam logic [1:0] OP_LD   = 2'b11;

  localparam logic [NB_W-1:0] CNT_MAX = NB_W'(WIDTH);
  localparam logic [NB_W-1:0] CNT_ONE = NB_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t           r_state, w_state_nx;
  logic [WIDTH-1:0] r_q, w_q_nx, w_up_src, w_dn_src;
  logic [NB_W-1:0]  r_cnt, w_cnt_nx, w_nbits_clamp;
  logic             r_dir, w_dir_nx;
  logic [1:0]       w_op;
  logic             w_in_lo, w_in_hi;

  // Clamp is applied once, at capture, so cnt never exceeds WIDTH.
  assign w_nbits_clamp = (nbits > CNT_MAX) ? CNT_MAX : nbits;

  // Bits entering the ends on a shift. Rotation only applies inside a burst.
`ifdef USR_ROTATE_EN
  assign w_in_lo = (r_state == S_SHIFT) ? r_q[WIDTH-1] : sin_lo;
  assign w_in_hi = (r_state == S_SHIFT) ? r_q[0]       : sin_hi;
`else
  assign w_in_lo = sin_lo;
  assign w_in_hi = sin_hi;
`endif

  assign w_up_src = {r_q[WIDTH-2:0], w_in_lo};
  assign w_dn_src = {w_in_hi, r_q[WIDTH-1:1]};

  // Next-state and register operation select
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_dir_nx   = r_dir;
    w_op       = OP_HOLD;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          // start overrides mode for this edge
          w_op       = OP_LD;
          w_dir_nx   = dir;
          w_cnt_nx   = w_nbits_clamp;
          w_state_nx = (w_nbits_clamp != '0) ? S_SHIFT : S_DONE;
        end else begin
          w_op = mode;
        end
      end
      S_SHIFT: begin
        w_op = r_dir ? OP_DN : OP_UP;
        if (r_cnt > CNT_ONE) begin
          w_cnt_nx = r_cnt - CNT_ONE;
        end else begin
          // last shift; saturate at zero rather than wrap
          w_cnt_nx   = '0;
          w_state_nx = S_DONE;
        end
      end
      S_DONE:  w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Bit-slice datapath
  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    usr_bit_cell u_cell (
      .i_op (w_op),
      .i_q  (r_q[g]),
      .i_up (w_up_src[g]),
      .i_dn (w_dn_src[g]),
      .i_ld (pdata[g]),
      .o_d  (w_q_nx[g])
    );
  end

  // State, count, direction and data registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_dir   <= 1'b0;
      r_q     <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_dir   <= w_dir_nx;
      r_q     <= w_q_nx;
    end
  end

  assign q       = r_q;
  assign sout_hi = r_q[WIDTH-1];
  assign sout_lo = r_q[0];
  assign busy    = (r_state == S_SHIFT);
  assign done    = (r_state == S_DONE);

endmodule

// File: tb/tb_univ_shift_register.sv
// Randomized bench for univ_shift_register (WIDTH=4). Expected values come
// from plain integer shift arithmetic per operation and per burst step.
module tb_univ_shift_register;

  localparam int W    = 4;
  localparam int NB_W = $clog2(W+1);

  logic            CLK, RST;
  logic [1:0]      mode;
  logic            sin_lo, sin_hi, start, dir;
  logic [W-1:0]    pdata, q;
  logic [NB_W-1:0] nbits;
  logic            sout_hi, sout_lo, busy, done;

  univ_shift_register #(.WIDTH(W)) dut (
    .CLK(CLK), .RST(RST), .mode(mode), .sin_lo(sin_lo), .sin_hi(sin_hi),
    .pdata(pdata), .start(start), .dir(dir), .nbits(nbits), .q(q),
    .sout_hi(sout_hi), .sout_lo(sout_lo), .busy(busy), .done(done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] m_q;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic busy_e, input logic done_e);
    chk({tag, ".q"},    32'(q),       32'(m_q));
    chk({tag, ".shi"},  32'(sout_hi), 32'((m_q >> (W-1)) & 1));
    chk({tag, ".slo"},  32'(sout_lo), 32'(m_q & 1));
    chk({tag, ".busy"}, 32'(busy),    32'(busy_e));
    chk({tag, ".done"}, 32'(done),    32'(done_e));
  endtask

  function automatic logic [W-1:0] sh_up(input logic [W-1:0] v, input logic b);
    return W'((32'(v) * 2 + 32'(b)) % (1 << W));
  endfunction

  function automatic logic [W-1:0] sh_dn(input logic [W-1:0] v, input logic b);
    return W'(32'(v) / 2 + 32'(b) * (1 << (W-1)));
  endfunction

  task automatic man_op(input logic [1:0] md, input logic sl, input logic sh,
                        input logic [W-1:0] pd);
    @(negedge CLK);
    mode = md; sin_lo = sl; sin_hi = sh; pdata = pd; start = 1'b0;
    dir = 1'($urandom); nbits = NB_W'($urandom);
    @(posedge CLK); #1;
    case (md)
      2'b01:   m_q = sh_up(m_q, sl);
      2'b10:   m_q = sh_dn(m_q, sh);
      2'b11:   m_q = pd;
      default: m_q = m_q;
    endcase
    check_outs("man", 1'b0, 1'b0);
  endtask

  // rnd=1: all other inputs randomized during the burst.
  // rnd=0: serial inputs held at fl/fh, start and mode=11 asserted throughout.
  task automatic burst(input logic [W-1:0] pd, input logic dr, input logic [NB_W-1:0] nb,
                       input bit rnd, input logic fl, input logic fh);
    int n;
    logic bl, bh;
    n = (int'(nb) > W) ? W : int'(nb);
    @(negedge CLK);
    start = 1'b1; dir = dr; nbits = nb; pdata = pd;
    mode = rnd ? 2'($urandom) : 2'b00; sin_lo = fl; sin_hi = fh;
    @(posedge CLK); #1;
    m_q = pd;
    check_outs("b_ld", n != 0, n == 0);
    for (int k = 1; k <= n + 1; k++) begin
      @(negedge CLK);
      if (rnd) begin
        start = 1'($urandom); mode = 2'($urandom); dir = 1'($urandom);
        nbits = NB_W'($urandom); pdata = W'($urandom);
        sin_lo = 1'($urandom); sin_hi = 1'($urandom);
      end else begin
        start = 1'b1; mode = 2'b11; dir = ~dr; pdata = ~pd;
        nbits = NB_W'($urandom); sin_lo = fl; sin_hi = fh;
      end
      @(posedge CLK); #1;
      if (k <= n) begin
`ifdef USR_ROTATE_EN
        bl = m_q[W-1]; bh = m_q[0];
`else
        bl = sin_lo; bh = sin_hi;
`endif
        m_q = dr ? sh_dn(m_q, bh) : sh_up(m_q, bl);
        check_outs("b_sh", k < n, k == n);
      end else begin
        check_outs("b_end", 1'b0, 1'b0);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    RST = 1'b0; mode = 2'b00; sin_lo = 1'b0; sin_hi = 1'b0; pdata = '0;
    start = 1'b0; dir = 1'b0; nbits = '0;
    m_q = '0;
    #12;
    check_outs("rst", 1'b0, 1'b0);
    @(negedge CLK); RST = 1'b1;

    // manual modes
    man_op(2'b11, 1'b0, 1'b0, 4'b1001);
    man_op(2'b01, 1'b1, 1'b0, 4'b0000);
    chk("man_up", 32'(q), 32'b0011);
    man_op(2'b10, 1'b1, 1'b0, 4'b0000);
    chk("man_dn", 32'(q), 32'b0001);
    man_op(2'b00, 1'b1, 1'b1, 4'b1111);
    chk("man_hold", 32'(q), 32'b0001);

    // asynchronous reset mid-cycle
    man_op(2'b11, 1'b0, 1'b0, 4'b1011);
    #2 RST = 1'b0;
    #1 m_q = '0;
    check_outs("arst", 1'b0, 1'b0);
    @(negedge CLK); RST = 1'b1;

    // burst up, 3 shifts, sin_lo=0: sout_hi 1,0,1,0
    burst(4'b1010, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0);
    chk("bup_final", 32'(q), 32'b0000);
    // nbits=0 and clamp
    burst(4'b0110, 1'b1, 3'd0, 1'b0, 1'b1, 1'b1);
    burst(4'b1001, 1'b0, 3'd7, 1'b0, 1'b1, 1'b0);
    // rotate vs serial fill
    burst(4'b1100, 1'b1, 3'd4, 1'b0, 1'b0, 1'b1);
`ifdef USR_ROTATE_EN
    chk("rot_final", 32'(q), 32'b1100);
`else
    chk("rot_final", 32'(q), 32'b1111);
`endif

    // reset in cycle 2 of a 4-shift burst
    @(negedge CLK); start = 1'b1; dir = 1'b0; nbits = 3'd4; pdata = 4'b1011;
    @(posedge CLK); #1;
    @(negedge CLK); start = 1'b0;
    @(posedge CLK); #1;
    #1 RST = 1'b0;
    #1 m_q = '0;
    check_outs("rst_mid", 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(posedge CLK); #1;
      check_outs("rst_hold", 1'b0, 1'b0);
    end
    @(negedge CLK); RST = 1'b1;
    burst(4'b0101, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0);

    // randomized mix
    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(0, 3) == 0)
        burst(W'($urandom), 1'($urandom), NB_W'($urandom), 1'b1,
              1'($urandom), 1'($urandom));
      else
        man_op(2'($urandom), 1'($urandom), 1'($urandom), W'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/univ_shift_register.md
# univ_shift_register

Parametrised universal shift register: WIDTH-bit register with hold, shift-up, shift-down and parallel-load modes, serial in/out at both ends, and a counted burst-shift engine (start/busy/done) that loads a word and shifts it N positions autonomously. It is the general-purpose successor to the fixed 4-bit serial-in/parallel-out shift register, for use as serializer, deserializer or delay line.

## Interface
- WIDTH, 4, register width in bits (≥2)
- NB_W, $clog2(WIDTH+1), width of burst count input (derived; not to be overridden)

- CLK  in  1  clock, rising-edge
- RST  in  1  asynchronous, active-low reset
- mode  in  2  manual op: 00 hold, 01 shift up, 10 shift down, 11 parallel load
- sin_lo  in  1  serial input entering q[0] on shift up
- sin_hi  in  1  serial input entering q[WIDTH-1] on shift down
- pdata  in  WIDTH  parallel load / burst load data
- start  in  1  burst request, sampled in IDLE only
- dir  in  1  burst direction: 0 up, 1 down; sampled with start
- nbits  in  NB_W  burst shift count; values > WIDTH clamp to WIDTH
- q  out  WIDTH  register contents
- sout_hi  out  1  = q[WIDTH-1] (combinational from q)
- sout_lo  out  1  = q[0]
- busy  out  1  high in SHIFT state
- done  out  1  one-cycle pulse on burst completion

## Operation
- Shift up: q <= {q[WIDTH-2:0], sin_lo}. Shift down: q <= {sin_hi, q[WIDTH-1:1]}.
- FSM states IDLE, SHIFT, DONE; encoding is implementer's choice.
- IDLE: start=0 → mode executes this edge. start=1 → start overrides mode; q <= pdata, dir latched, cnt <= min(nbits, WIDTH); next SHIFT if cnt≠0, else DONE.
- SHIFT: one shift per cycle in latched dir, cnt decrements; on the shift with cnt=1 → DONE. mode, start, dir, nbits ignored.
- DONE: q holds; done=1 for this cycle only; next IDLE. start/mode ignored in DONE.
- Serial inputs during burst: sin_lo/sin_hi sampled live each SHIFT cycle (see Configuration for rotate).
- Arithmetic: cnt is NB_W bits, never wraps; clamp applied at capture.

## Timing
- Reset (RST=0, asynchronous): q=0, sout_hi=0, sout_lo=0, busy=0, done=0, state IDLE, cnt=0. Reset mid-burst aborts immediately; no done pulse.
- Manual ops: result visible on q one cycle after the sampling edge.
- Burst of N (1..WIDTH): load at edge 0, shifts at edges 1..N, busy high cycles 1..N, done high cycle N+1, next start accepted at edge N+2 earliest. Total N+2 cycles start-to-start.
- N=0: load at edge 0, busy never rises, done pulses cycle 1.
- sout_hi/sout_lo after edge k of a burst reflect the bit to be shifted out next.
- Release of RST must be synchronous to CLK by the integrating level.

## Configuration
- USR_ROTATE_EN defined: during burst shifts the outgoing end bit re-enters the opposite end (up: q[0] <= q[WIDTH-1]; down: q[WIDTH-1] <= q[0]); sin_lo/sin_hi ignored in SHIFT. A WIDTH-count burst returns q to the loaded value.
- Undefined: burst shifts take sin_lo/sin_hi as in manual shifts. Manual modes are identical either way.

## Test plan
- Reset: drive q to 4'b1011, assert RST=0 mid-cycle → q=0, busy=0, done=0 immediately, without waiting for CLK.
- Manual: WIDTH=4, mode=11 pdata=4'b1001, then mode=01 sin_lo=1 → q=4'b0011; mode=10 sin_hi=0 → q=4'b0001; mode=00 → holds.
- Burst up: pdata=4'b1010, nbits=3, dir=0, sin_lo=0 → sout_hi sequence 1,0,1,0 after edges 0..3; q=4'b0000 at DONE; busy 3 cycles, done 1 cycle at cycle 4.
- Burst edge cases: nbits=0 → q=pdata, done cycle 1, busy never high; nbits=7 (WIDTH=4) → clamped to 4 shifts; start and mode=11 asserted during SHIFT → ignored.
- Rotate (USR_ROTATE_EN): pdata=4'b1100, nbits=4, dir=1 → q=4'b1100 at done; without macro and sin_hi=1 → q=4'b1111.
- Reset mid-burst: RST=0 at cycle 2 of a 4-shift burst → q=0, no done; fresh start after release completes normally.
